wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Two-master to one-slave Wishbone classic arbiter.
- Lets the core's instruction fetch port (iwbm) and data port (dwbm) share a single external memory bus.
- Sits between the core's bus ports and the unified memory/peripheral interconnect.
- Grants the bus per transaction, holds the grant until termination, and routes ack/err/data back only to the owner.

Parameters:
FAIR, 0, 0 = data port always wins ties; 1 = on a tie, grant goes to the port not granted last
TIMEOUT_CYCLES, 255, cycles without ack/err before a forced error (used only with the optional feature); 8-bit counter, legal range 2..255

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
iwbs_cyc_i  in  1  instruction master cycle
iwbs_stb_i  in  1  instruction master strobe
iwbs_addr_i  in  32  instruction address
iwbs_dat_o  out  32  read data to instruction master
iwbs_ack_o  out  1  ack to instruction master
iwbs_err_o  out  1  error to instruction master
dwbs_cyc_i  in  1  data master cycle
dwbs_stb_i  in  1  data master strobe
dwbs_we_i  in  1  data write enable
dwbs_sel_i  in  4  byte selects
dwbs_addr_i  in  32  data address
dwbs_dat_i  in  32  write data
dwbs_dat_o  out  32  read data to data master
dwbs_ack_o  out  1  ack to data master
dwbs_err_o  out  1  error to data master
wbm_cyc_o  out  1  shared bus cycle
wbm_stb_o  out  1  shared bus strobe
wbm_we_o  out  1  shared bus write enable
wbm_sel_o  out  4  shared bus byte selects
wbm_addr_o  out  32  shared bus address
wbm_dat_o  out  32  shared bus write data
wbm_dat_i  in  32  shared bus read data
wbm_ack_i  in  1  shared bus ack
wbm_err_i  in  1  shared bus error
grant_o  out  2  {data, instr} one-hot owner; 00 when idle

Behaviour:
- State machine: IDLE, OWN_I, OWN_D. State and last_grant are registered; reset is asynchronous.
- Reset: state = IDLE, last_grant = I.
  - All outputs 0: cyc/stb/we/sel/addr/dat_o, ack/err, grant_o.
  - A reset asserted mid-transaction drops wbm_cyc_o/wbm_stb_o immediately (asynchronously).
- Request: req_x = x_cyc_i & x_stb_i.
- IDLE transitions:
  - Only req_d -> OWN_D.
  - Only req_i -> OWN_I.
  - Both requesting, FAIR=0 -> OWN_D.
  - Both requesting, FAIR=1 -> the port that is not last_grant.
  - No request -> stay IDLE.
  - Entering OWN_x updates last_grant.
- Latency: a request seen in IDLE at edge N is driven onto wbm_* during cycle N+1.
- Output mux, combinational from registered state:
  - OWN_D: wbm_cyc/stb/we/sel/addr/dat_o = dwbs_* inputs.
  - OWN_I: wbm_cyc/stb/addr = iwbs_*; we = 0, sel = 4'hF, dat_o = 0.
  - IDLE: all wbm_* = 0.
- Return path:
  - wbm_dat_i is broadcast to both x_dat_o.
  - ack/err are gated: x_ack_o = wbm_ack_i & own_x; x_err_o = wbm_err_i & own_x.
  - The non-owner never sees ack/err.
- Release from OWN_x to IDLE on:
  - wbm_ack_i | wbm_err_i (transaction terminated); or
  - owner's x_cyc_i = 0 (abort).
  - After release, at least one IDLE cycle occurs between owners, so back-to-back grants are 2 cycles apart.
- A non-owner request stays pending; its master holds stb until granted and acked.
- wbm_ack_i/err_i arriving in IDLE are ignored.
- ack and err asserted together: both are forwarded to the owner; err has priority in the master's interpretation.

Optional Feature:
- Macro WB_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on entering OWN_x and increments each owner cycle with no ack/err.
  - When it reaches TIMEOUT_CYCLES-1 and no ack/err arrives:
    - x_err_o = 1 to the owner for exactly one cycle.
    - wbm_cyc_o/wbm_stb_o are forced to 0 in that cycle.
    - State returns to IDLE.
  - Counter reset value 0.
- Undefined: no counter; the arbiter waits indefinitely for ack/err or an owner abort.

Test Plan:
- Reset held, then released with no requests -> all outputs 0, grant_o = 00 for 10 cycles.
- Instruction-only read to addr 0x8000_0000, slave acks after 2 cycles with 0x0000_0013:
  - wbm_addr_o = 0x8000_0000 from cycle 1.
  - iwbs_ack_o = 1 with iwbs_dat_o = 0x0000_0013; dwbs_ack_o stays 0.
  - grant_o returns to 00 the next cycle.
- Simultaneous requests, FAIR=0 -> data granted first (grant_o = 10); after its ack, instruction granted 2 cycles later (01).
- Simultaneous requests repeated 4 times, FAIR=1 -> grant order D, I, D, I.
- Data write: addr 0x1000_0004, dat 0xDEAD_BEEF, sel 4'b0011 -> wbm_we_o = 1, wbm_sel_o = 0011, wbm_dat_o = 0xDEAD_BEEF; dwbs_ack_o pulses.
- With WB_BUS_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave never acks:
  - Owner sees err_o for one cycle at the 8th owned cycle.
  - wbm_cyc_o is 0 in that cycle; the arbiter returns to IDLE.
  - Without the macro, cyc stays high for 100+ cycles.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
//
// Two-master to one-slave Wishbone classic arbiter. The core's instruction
// fetch port (iwbs_*) and data port (dwbs_*) share one external memory bus
// (wbm_*). The bus is granted per transaction, the grant is held until the
// slave terminates the cycle (ack or err) or the owner drops cyc, and the
// slave's ack/err are returned only to the current owner.
//
// Parameters:
//   FAIR            0: data port wins ties.
//                   1: on a tie, the port not granted last wins.
//   TIMEOUT_CYCLES  Owned cycles without ack/err before a forced error
//                   (2..255). Only used when WB_BUS_ARBITER_TIMEOUT_EN is
//                   defined.
//
// Optional feature (compile-time macro WB_BUS_ARBITER_TIMEOUT_EN):
//   Defined   - an 8-bit watchdog ends a stalled transaction with a one-cycle
//               err to the owner, dropping wbm_cyc_o/wbm_stb_o in that cycle.
//   Undefined - the arbiter waits indefinitely for ack/err or an owner abort.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   iwbs_*              instruction master side (read only)
//   dwbs_*              data master side (read/write)
//   wbm_*               shared bus towards the memory/peripheral interconnect
//   grant_o             {data, instr} one-hot owner, 2'b00 when idle
// -----------------------------------------------------------------------------
module wb_bus_arbiter #(
    parameter int FAIR           = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    // Instruction master
    input  logic        iwbs_cyc_i,
    input  logic        iwbs_stb_i,
    input  logic [31:0] iwbs_addr_i,
    output logic [31:0] iwbs_dat_o,
    output logic        iwbs_ack_o,
    output logic        iwbs_err_o,

    // Data master
    input  logic        dwbs_cyc_i,
    input  logic        dwbs_stb_i,
    input  logic        dwbs_we_i,
    input  logic [3:0]  dwbs_sel_i,
    input  logic [31:0] dwbs_addr_i,
    input  logic [31:0] dwbs_dat_i,
    output logic [31:0] dwbs_dat_o,
    output logic        dwbs_ack_o,
    output logic        dwbs_err_o,

    // Shared bus
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,

    // Current owner
    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN_I = 2'b01,
        ST_OWN_D = 2'b10
    } state_e;

    localparam bit FAIR_EN = (FAIR != 0);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_bus_arbiter: TIMEOUT_CYCLES must be within 2..255");
    end

    state_e state_q, state_d;
    // 1 = data port was granted last, 0 = instruction port.
    logic   last_grant_q, last_grant_d;

    logic   req_instr;
    logic   req_data;
    logic   own_instr;
    logic   own_data;
    logic   owned;
    logic   owner_cyc;
    logic   slave_term;
    logic   timeout_hit;
    logic   release_bus;

    assign req_instr  = iwbs_cyc_i & iwbs_stb_i;
    assign req_data   = dwbs_cyc_i & dwbs_stb_i;

    assign own_instr  = (state_q == ST_OWN_I);
    assign own_data   = (state_q == ST_OWN_D);
    assign owned      = own_instr | own_data;

    assign owner_cyc  = own_data ? dwbs_cyc_i : iwbs_cyc_i;
    assign slave_term = wbm_ack_i | wbm_err_i;

    // ---------------------------------------------------------------------
    // Watchdog
    // ---------------------------------------------------------------------
`ifdef WB_BUS_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero while idle, so the first owned cycle always starts at 0.
    assign tmo_cnt_d   = owned ? (tmo_cnt_q + 8'd1) : 8'd0;

    // Fires in the TIMEOUT_CYCLES-th owned cycle unless the slave answers in
    // that very cycle; a real ack/err always takes precedence.
    assign timeout_hit = owned & ~slave_term & (tmo_cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Ownership ends on slave termination, watchdog expiry, or owner abort.
    assign release_bus = slave_term | timeout_hit | ~owner_cyc;

    // ---------------------------------------------------------------------
    // Arbitration FSM
    // ---------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case statement leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;

        case (state_q)
            ST_IDLE: begin
                // Data wins unless the instruction port also requests and
                // fairness says data went last.
                if (req_data && (!req_instr || !FAIR_EN || !last_grant_q)) begin
                    state_d      = ST_OWN_D;
                    last_grant_d = 1'b1;
                end else if (req_instr) begin
                    state_d      = ST_OWN_I;
                    last_grant_d = 1'b0;
                end
            end

            // Releasing always passes through IDLE, giving one dead cycle
            // between owners.
            ST_OWN_I, ST_OWN_D: begin
                if (release_bus) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // ---------------------------------------------------------------------
    // Request path: mux decoded from registered state, so an asynchronous
    // reset drops wbm_cyc_o/wbm_stb_o immediately.
    // ---------------------------------------------------------------------
    always_comb begin
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_sel_o  = 4'h0;
        wbm_addr_o = 32'h0;
        wbm_dat_o  = 32'h0;

        case (state_q)
            ST_OWN_D: begin
                wbm_cyc_o  = dwbs_cyc_i & ~timeout_hit;
                wbm_stb_o  = dwbs_stb_i & ~timeout_hit;
                wbm_we_o   = dwbs_we_i;
                wbm_sel_o  = dwbs_sel_i;
                wbm_addr_o = dwbs_addr_i;
                wbm_dat_o  = dwbs_dat_i;
            end

            // Instruction fetches are always full-word reads.
            ST_OWN_I: begin
                wbm_cyc_o  = iwbs_cyc_i & ~timeout_hit;
                wbm_stb_o  = iwbs_stb_i & ~timeout_hit;
                wbm_sel_o  = 4'hF;
                wbm_addr_o = iwbs_addr_i;
            end

            default: begin
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Return path: data is broadcast, terminations reach only the owner.
    // ack and err may both be forwarded; the master gives err priority.
    // ---------------------------------------------------------------------
    assign iwbs_dat_o = wbm_dat_i;
    assign dwbs_dat_o = wbm_dat_i;

    assign iwbs_ack_o = wbm_ack_i & own_instr;
    assign dwbs_ack_o = wbm_ack_i & own_data;
    assign iwbs_err_o = (wbm_err_i | timeout_hit) & own_instr;
    assign dwbs_err_o = (wbm_err_i | timeout_hit) & own_data;

    assign grant_o    = {own_data, own_instr};

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_bus_arbiter
//
// Two arbiter instances run side by side: index 0 with FAIR=0, index 1 with
// FAIR=1 (both TIMEOUT_CYCLES=8). Inputs change 1 ns after a rising edge and
// outputs are sampled on the falling edge. Directed scenarios use constant
// expectations; the random scenario keeps an owner/last-grant reference model.
// -----------------------------------------------------------------------------
module tb_wb_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;

    logic        i_cyc   [2];
    logic        i_stb   [2];
    logic [31:0] i_addr  [2];
    logic [31:0] i_rdat  [2];
    logic        i_ack   [2];
    logic        i_err   [2];

    logic        d_cyc   [2];
    logic        d_stb   [2];
    logic        d_we    [2];
    logic [3:0]  d_sel   [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdat  [2];
    logic [31:0] d_rdat  [2];
    logic        d_ack   [2];
    logic        d_err   [2];

    logic        m_cyc   [2];
    logic        m_stb   [2];
    logic        m_we    [2];
    logic [3:0]  m_sel   [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdat  [2];
    logic [31:0] s_rdat  [2];
    logic        s_ack   [2];
    logic        s_err   [2];
    logic [1:0]  grant   [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_bus_arbiter #(
            .FAIR           (g),
            .TIMEOUT_CYCLES (TO)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .iwbs_cyc_i  (i_cyc[g]),
            .iwbs_stb_i  (i_stb[g]),
            .iwbs_addr_i (i_addr[g]),
            .iwbs_dat_o  (i_rdat[g]),
            .iwbs_ack_o  (i_ack[g]),
            .iwbs_err_o  (i_err[g]),
            .dwbs_cyc_i  (d_cyc[g]),
            .dwbs_stb_i  (d_stb[g]),
            .dwbs_we_i   (d_we[g]),
            .dwbs_sel_i  (d_sel[g]),
            .dwbs_addr_i (d_addr[g]),
            .dwbs_dat_i  (d_wdat[g]),
            .dwbs_dat_o  (d_rdat[g]),
            .dwbs_ack_o  (d_ack[g]),
            .dwbs_err_o  (d_err[g]),
            .wbm_cyc_o   (m_cyc[g]),
            .wbm_stb_o   (m_stb[g]),
            .wbm_we_o    (m_we[g]),
            .wbm_sel_o   (m_sel[g]),
            .wbm_addr_o  (m_addr[g]),
            .wbm_dat_o   (m_wdat[g]),
            .wbm_dat_i   (s_rdat[g]),
            .wbm_ack_i   (s_ack[g]),
            .wbm_err_i   (s_err[g]),
            .grant_o     (grant[g])
        );
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (no comparisons in here)
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        for (int k = 0; k < 2; k++) begin
            i_cyc[k]  = 1'b0;  i_stb[k]  = 1'b0;  i_addr[k] = 32'h0;
            d_cyc[k]  = 1'b0;  d_stb[k]  = 1'b0;  d_we[k]   = 1'b0;
            d_sel[k]  = 4'h0;  d_addr[k] = 32'h0; d_wdat[k] = 32'h0;
            s_rdat[k] = 32'h0; s_ack[k]  = 1'b0;  s_err[k]  = 1'b0;
        end
    endtask

    function automatic logic [76:0] out_vec(int k);
        return {grant[k], m_cyc[k], m_stb[k], m_we[k], m_sel[k], m_addr[k],
                m_wdat[k], i_ack[k], i_err[k], d_ack[k], d_err[k]};
    endfunction

    // Arbitration rule from the specification: 0 none, 1 instr, 2 data.
    function automatic int pick(int fair, int last, bit ri, bit rd);
        if (ri && rd) return (fair == 0) ? 2 : ((last == 2) ? 1 : 2);
        if (rd) return 2;
        if (ri) return 1;
        return 0;
    endfunction

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        quiet();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (out_vec(k) !== '0) $display("FAIL reset_held[%0d]: got %h expected 0", k, out_vec(k));
            else n_pass++;
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (out_vec(k) !== '0) $display("FAIL reset_idle[%0d] cycle %0d: got %h expected 0", k, c, out_vec(k));
                else n_pass++;
            end
        end
    endtask

    task automatic test_tie_fair();
        logic [1:0] exp_g;
        for (int r = 0; r < 4; r++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                i_cyc[k] = 1'b1; i_stb[k] = 1'b1; i_addr[k] = 32'h100 + r;
                d_cyc[k] = 1'b1; d_stb[k] = 1'b1; d_addr[k] = 32'h200 + r;
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (grant[k] !== 2'b00) $display("FAIL tie_latency[%0d] round %0d: got %b expected 00", k, r, grant[k]);
                else n_pass++;
            end
            tick();
            for (int k = 0; k < 2; k++) s_ack[k] = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                exp_g = (k == 0 || r % 2 == 0) ? 2'b10 : 2'b01;
                n_checks++;
                if ({grant[k], d_ack[k], i_ack[k], m_addr[k]} !==
                    {exp_g, exp_g, ((exp_g == 2'b10) ? 32'h200 + r : 32'h100 + r)})
                    $display("FAIL tie_grant[%0d] round %0d: got grant=%b dack=%b iack=%b addr=%h expected grant=%b",
                             k, r, grant[k], d_ack[k], i_ack[k], m_addr[k], exp_g);
                else n_pass++;
            end
            tick();
            quiet();
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (grant[k] !== 2'b00) $display("FAIL tie_release[%0d] round %0d: got %b expected 00", k, r, grant[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_instr_read();
        // A stray ack while idle must not reach anyone nor start a grant.
        tick();
        s_ack[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({i_ack[0], d_ack[0], grant[0]} !== 4'b0) $display("FAIL idle_ack: got iack=%b dack=%b grant=%b expected all 0", i_ack[0], d_ack[0], grant[0]);
        else n_pass++;
        tick();
        s_ack[0] = 1'b0;
        i_cyc[0] = 1'b1; i_stb[0] = 1'b1; i_addr[0] = 32'h8000_0000;
        @(negedge clk);
        n_checks++;
        if (grant[0] !== 2'b00) $display("FAIL ird_latency: got %b expected 00", grant[0]);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if ({grant[0], m_cyc[0], m_stb[0], m_we[0], m_sel[0], m_addr[0], m_wdat[0]} !==
            {2'b01, 1'b1, 1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'h0})
            $display("FAIL ird_bus: got grant=%b cyc=%b we=%b sel=%h addr=%h dat=%h expected 01/1/0/f/80000000/0",
                     grant[0], m_cyc[0], m_we[0], m_sel[0], m_addr[0], m_wdat[0]);
        else n_pass++;
        tick();
        s_ack[0] = 1'b1; s_rdat[0] = 32'h0000_0013;
        @(negedge clk);
        n_checks++;
        if ({i_ack[0], i_rdat[0], d_ack[0], i_err[0]} !== {1'b1, 32'h13, 1'b0, 1'b0})
            $display("FAIL ird_ack: got iack=%b idat=%h dack=%b ierr=%b expected 1/00000013/0/0", i_ack[0], i_rdat[0], d_ack[0], i_err[0]);
        else n_pass++;
        tick();
        quiet();
        @(negedge clk);
        n_checks++;
        if ({grant[0], m_cyc[0]} !== 3'b0) $display("FAIL ird_release: got grant=%b cyc=%b expected 00/0", grant[0], m_cyc[0]);
        else n_pass++;
    endtask

    task automatic test_tie_fixed();
        tick();
        i_cyc[0] = 1'b1; i_stb[0] = 1'b1; i_addr[0] = 32'h0000_0040;
        d_cyc[0] = 1'b1; d_stb[0] = 1'b1; d_addr[0] = 32'h2000_0000;
        tick();
        s_ack[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({grant[0], d_ack[0], i_ack[0]} !== 4'b1010) $display("FAIL fix_first: got grant=%b dack=%b iack=%b expected 10/1/0", grant[0], d_ack[0], i_ack[0]);
        else n_pass++;
        tick();
        s_ack[0] = 1'b0; d_cyc[0] = 1'b0; d_stb[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (grant[0] !== 2'b00) $display("FAIL fix_gap: got %b expected 00", grant[0]);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if ({grant[0], m_addr[0]} !== {2'b01, 32'h0000_0040}) $display("FAIL fix_second: got grant=%b addr=%h expected 01/00000040", grant[0], m_addr[0]);
        else n_pass++;
        tick();
        s_ack[0] = 1'b1;
        tick();
        quiet();
        tick();
    endtask

    task automatic test_data_write();
        tick();
        d_cyc[0] = 1'b1; d_stb[0] = 1'b1; d_we[0] = 1'b1; d_sel[0] = 4'b0011;
        d_addr[0] = 32'h1000_0004; d_wdat[0] = 32'hDEAD_BEEF;
        tick();
        @(negedge clk);
        n_checks++;
        if ({grant[0], m_cyc[0], m_stb[0], m_we[0], m_sel[0], m_addr[0], m_wdat[0]} !==
            {2'b10, 1'b1, 1'b1, 1'b1, 4'b0011, 32'h1000_0004, 32'hDEAD_BEEF})
            $display("FAIL dwr_bus: got grant=%b we=%b sel=%b addr=%h dat=%h expected 10/1/0011/10000004/deadbeef",
                     grant[0], m_we[0], m_sel[0], m_addr[0], m_wdat[0]);
        else n_pass++;
        tick();
        s_ack[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({d_ack[0], i_ack[0], d_err[0]} !== 3'b100) $display("FAIL dwr_ack: got dack=%b iack=%b derr=%b expected 1/0/0", d_ack[0], i_ack[0], d_err[0]);
        else n_pass++;
        tick();
        quiet();
        @(negedge clk);
        n_checks++;
        if ({grant[0], d_ack[0]} !== 3'b0) $display("FAIL dwr_pulse: got grant=%b dack=%b expected 00/0", grant[0], d_ack[0]);
        else n_pass++;
    endtask

    task automatic test_err_abort();
        // Slave error goes to the instruction owner only.
        tick();
        i_cyc[0] = 1'b1; i_stb[0] = 1'b1; i_addr[0] = 32'h0000_0100;
        tick();
        s_err[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({i_err[0], i_ack[0], d_err[0]} !== 3'b100) $display("FAIL err_route: got ierr=%b iack=%b derr=%b expected 1/0/0", i_err[0], i_ack[0], d_err[0]);
        else n_pass++;
        tick();
        quiet();
        // Data owner aborts by dropping cyc.
        tick();
        d_cyc[0] = 1'b1; d_stb[0] = 1'b1; d_addr[0] = 32'h3000_0000;
        tick();
        tick();
        d_cyc[0] = 1'b0; d_stb[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({grant[0], m_cyc[0]} !== 3'b100) $display("FAIL abort_cycle: got grant=%b cyc=%b expected 10/0", grant[0], m_cyc[0]);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (grant[0] !== 2'b00) $display("FAIL abort_release: got %b expected 00", grant[0]);
        else n_pass++;
        // ack and err together are both forwarded.
        d_cyc[0] = 1'b1; d_stb[0] = 1'b1;
        tick();
        tick();
        s_ack[0] = 1'b1; s_err[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({d_ack[0], d_err[0], i_ack[0], i_err[0]} !== 4'b1100) $display("FAIL ack_err: got dack=%b derr=%b iack=%b ierr=%b expected 1/1/0/0", d_ack[0], d_err[0], i_ack[0], i_err[0]);
        else n_pass++;
        tick();
        quiet();
        tick();
    endtask

    task automatic test_async_reset();
        tick();
        d_cyc[0] = 1'b1; d_stb[0] = 1'b1; d_addr[0] = 32'h4000_0000;
        tick();
        @(negedge clk);
        n_checks++;
        if (m_cyc[0] !== 1'b1) $display("FAIL arst_pre: got cyc=%b expected 1", m_cyc[0]);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({m_cyc[0], m_stb[0], grant[0]} !== 4'b0) $display("FAIL arst_drop: got cyc=%b stb=%b grant=%b expected 0/0/00", m_cyc[0], m_stb[0], grant[0]);
        else n_pass++;
        quiet();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        tick();
        i_cyc[0] = 1'b1; i_stb[0] = 1'b1; i_addr[0] = 32'h5000_0000;
`ifdef WB_BUS_ARBITER_TIMEOUT_EN
        for (int c = 1; c <= TO; c++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if ({grant[0], m_cyc[0], m_stb[0], i_err[0], d_err[0]} !==
                {2'b01, (c == TO) ? 4'b0010 : 4'b1100})
                $display("FAIL timeout cycle %0d: got grant=%b cyc=%b stb=%b ierr=%b derr=%b", c, grant[0], m_cyc[0], m_stb[0], i_err[0], d_err[0]);
            else n_pass++;
        end
        // Master still holds its request here; the arbiter must have gone idle.
        tick();
        @(negedge clk);
        n_checks++;
        if ({grant[0], i_err[0]} !== 3'b0) $display("FAIL timeout_idle: got grant=%b ierr=%b expected 00/0", grant[0], i_err[0]);
        else n_pass++;
`else
        tick();
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            n_checks++;
            if ({grant[0], m_cyc[0], i_err[0]} !== 4'b0110) $display("FAIL no_timeout cycle %0d: got grant=%b cyc=%b ierr=%b expected 01/1/0", c, grant[0], m_cyc[0], i_err[0]);
            else n_pass++;
            tick();
        end
`endif
        quiet();
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (grant[0] !== 2'b00) $display("FAIL timeout_end: got %b expected 00", grant[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        int          owner [2];
        int          last  [2];
        int          wcnt  [2];
        bit          pi    [2];
        bit          pd    [2];
        logic [31:0] ia    [2];
        logic [31:0] da    [2];
        logic [31:0] dd    [2];
        logic [3:0]  ds    [2];
        logic        dw    [2];
        logic [1:0]  e_g;
        logic        oc;
        logic [70:0] e_bus;
        int          r;

        rst = 1'b1;
        quiet();
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            owner[k] = 0; last[k] = 1; wcnt[k] = 0; pi[k] = 0; pd[k] = 0;
            ia[k] = 0; da[k] = 0; dd[k] = 0; ds[k] = 0; dw[k] = 0;
        end

        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                i_cyc[k] = pi[k]; i_stb[k] = pi[k]; i_addr[k] = ia[k];
                d_cyc[k] = pd[k]; d_stb[k] = pd[k]; d_addr[k] = da[k];
                d_we[k]  = dw[k]; d_sel[k] = ds[k]; d_wdat[k] = dd[k];
                s_rdat[k] = $urandom;
                s_ack[k] = 1'b0; s_err[k] = 1'b0;
                if (owner[k] != 0 && wcnt[k] == 0) begin
                    r = $urandom_range(0, 15);
                    s_err[k] = (r <= 1);
                    s_ack[k] = (r >= 1);
                end else if (owner[k] == 0 && $urandom_range(0, 7) == 0) begin
                    s_ack[k] = 1'b1;
                end
            end

            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                oc    = (owner[k] == 1) ? pi[k] : (owner[k] == 2) ? pd[k] : 1'b0;
                e_g   = (owner[k] == 2) ? 2'b10 : (owner[k] == 1) ? 2'b01 : 2'b00;
                if (owner[k] == 2)      e_bus = {oc, oc, dw[k], ds[k], da[k], dd[k]};
                else if (owner[k] == 1) e_bus = {oc, oc, 1'b0, 4'hF, ia[k], 32'h0};
                else                    e_bus = '0;

                n_checks++;
                if (grant[k] !== e_g) $display("FAIL rnd_grant[%0d] cycle %0d: got %b expected %b", k, cyc, grant[k], e_g);
                else n_pass++;
                n_checks++;
                if ({m_cyc[k], m_stb[k], m_we[k], m_sel[k], m_addr[k], m_wdat[k]} !== e_bus)
                    $display("FAIL rnd_bus[%0d] cycle %0d: got %h expected %h", k, cyc,
                             {m_cyc[k], m_stb[k], m_we[k], m_sel[k], m_addr[k], m_wdat[k]}, e_bus);
                else n_pass++;
                n_checks++;
                if ({i_ack[k], i_err[k], d_ack[k], d_err[k], i_rdat[k], d_rdat[k]} !==
                    {s_ack[k] & (owner[k] == 1), s_err[k] & (owner[k] == 1),
                     s_ack[k] & (owner[k] == 2), s_err[k] & (owner[k] == 2), s_rdat[k], s_rdat[k]})
                    $display("FAIL rnd_return[%0d] cycle %0d: got iack=%b ierr=%b dack=%b derr=%b owner=%0d",
                             k, cyc, i_ack[k], i_err[k], d_ack[k], d_err[k], owner[k]);
                else n_pass++;

                // Advance the reference model to the next cycle.
                if (owner[k] == 0) begin
                    owner[k] = pick(k, last[k], pi[k], pd[k]);
                    if (owner[k] != 0) begin
                        last[k] = owner[k];
                        wcnt[k] = $urandom_range(0, 3);
                    end
                end else if (s_ack[k] || s_err[k] || !oc) begin
                    if (owner[k] == 1) pi[k] = 0;
                    else               pd[k] = 0;
                    owner[k] = 0;
                end else begin
                    wcnt[k]--;
                end

                // Masters: occasional abort, otherwise new requests at random.
                if (pi[k] && $urandom_range(0, 31) == 0) pi[k] = 0;
                else if (!pi[k] && $urandom_range(0, 2) == 0) begin
                    pi[k] = 1; ia[k] = $urandom;
                end
                if (pd[k] && $urandom_range(0, 31) == 0) pd[k] = 0;
                else if (!pd[k] && $urandom_range(0, 2) == 0) begin
                    pd[k] = 1; da[k] = $urandom; dd[k] = $urandom;
                    ds[k] = 4'($urandom_range(0, 15)); dw[k] = 1'($urandom_range(0, 1));
                end
            end
            tick();
        end
        quiet();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_tie_fair();
        test_instr_read();
        test_tie_fixed();
        test_data_write();
        test_err_abort();
        test_async_reset();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
